// File: rtl/wb_mem_slave_pkg.sv
// wb_mem_slave_pkg: shared FSM state type and bus width constants
package wb_mem_slave_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
endpackage

// File: rtl/wb_mem_slave_if.sv
// wb_mem_slave_if: Wishbone classic bus bundle with master/slave views
interface wb_mem_slave_if;
    import wb_mem_slave_pkg::*;
    logic [ADDR_W-1:0] adr_i;
    logic [DATA_W-1:0] dat_i;
    logic [DATA_W-1:0] dat_o;
    logic              we_i;
    logic [3:0]        sel_i;
    logic              stb_i;
    logic              cyc_i;
    logic              ack_o;
    modport master (output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, input dat_o, ack_o);
    modport slave  (input adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, output dat_o, ack_o);
endinterface

// File: rtl/wb_mem_array.sv
// wb_mem_array: single-port RAM, 2-lane byte write enable, registered read
module wb_mem_array
    import wb_mem_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // byte-lane writes; storage itself is never reset
    always_ff @(posedge clk) begin
        if (en && we && be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (en && we && be[1]) mem[addr][15:8] <= wdata[15:8];
    end

    // read register only loads on reads, so it holds across writes and idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end
endmodule

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone memory slave with programmable wait states
module wb_mem_slave
    import wb_mem_slave_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input logic          clk,
    input logic          reset,
    wb_mem_slave_if.slave bus
);
    state_t                state, state_d;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] adr_q, addr;
    logic [DATA_W-1:0]     dat_q, wdata;
    logic                  we_q, we;
    logic [1:0]            sel_q, sel;
    logic                  req, idle, en;
    logic                  unused;

    assign unused = ^{bus.adr_i[ADDR_W-1:DEPTH_LOG2], bus.sel_i[3:2]};

    // next state plus RAM port; in IDLE the live bus feeds the RAM so WAIT_STATES=0 needs no extra cycle
    always_comb begin
        req     = bus.cyc_i && bus.stb_i;
        idle    = state == IDLE;
        state_d = idle ? (req ? (WAIT_STATES == 0 ? ACK : WAIT) : IDLE)
                : state == WAIT ? (!req ? IDLE : cnt == 4'd1 ? ACK : WAIT)
                : IDLE;
        en      = !reset && state_d == ACK;
        addr    = idle ? bus.adr_i[DEPTH_LOG2-1:0] : adr_q;
        wdata   = idle ? bus.dat_i : dat_q;
        we      = idle ? bus.we_i : we_q;
        sel     = idle ? bus.sel_i[1:0] : sel_q;
    end

    // state register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= idle && req ? 4'(WAIT_STATES) : state == WAIT ? cnt - 4'd1 : cnt;
        end
    end

    // request fields captured only when a transfer is accepted from IDLE
    always_ff @(posedge clk) begin
        if (idle && req) begin
            adr_q <= bus.adr_i[DEPTH_LOG2-1:0];
            dat_q <= bus.dat_i;
            we_q  <= bus.we_i;
            sel_q <= bus.sel_i[1:0];
        end
    end

    assign bus.ack_o = state == ACK;

    wb_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .we    (we),
        .be    (sel),
        .addr  (addr),
        .wdata (wdata),
        .rdata (bus.dat_o)
    );
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: directed checks of wb_mem_slave with 1 and 0 wait states
module tb_wb_mem_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_mem_slave_if b1 ();
    wb_mem_slave_if b0 ();

    wb_mem_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .bus(b1));
    wb_mem_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(b0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [15:0] a, input logic [15:0] d, input logic [3:0] s, input string tag);
        b1.adr_i = a; b1.dat_i = d; b1.sel_i = s; b1.we_i = 1'b1; b1.cyc_i = 1'b1; b1.stb_i = 1'b1;
        tick();
        chk({tag, "_ack_wait"}, 16'(b1.ack_o), 16'h0);
        b1.adr_i = ~a; b1.dat_i = ~d; b1.sel_i = 4'b0011; b1.we_i = 1'b0;
        tick();
        chk({tag, "_ack"}, 16'(b1.ack_o), 16'h1);
        b1.cyc_i = 1'b0; b1.stb_i = 1'b0;
        tick();
        chk({tag, "_ack_end"}, 16'(b1.ack_o), 16'h0);
    endtask

    task automatic rd1(input logic [15:0] a, input logic [15:0] exp, input string tag);
        b1.adr_i = a; b1.we_i = 1'b0; b1.sel_i = 4'b0000; b1.cyc_i = 1'b1; b1.stb_i = 1'b1;
        tick();
        chk({tag, "_ack_wait"}, 16'(b1.ack_o), 16'h0);
        b1.adr_i = a ^ 16'h0001;
        tick();
        chk({tag, "_ack"}, 16'(b1.ack_o), 16'h1);
        chk({tag, "_data"}, b1.dat_o, exp);
        b1.cyc_i = 1'b0; b1.stb_i = 1'b0;
        tick();
        chk({tag, "_ack_end"}, 16'(b1.ack_o), 16'h0);
        chk({tag, "_hold"}, b1.dat_o, exp);
    endtask

    task automatic wr0(input logic [15:0] a, input logic [15:0] d, input string tag);
        b0.adr_i = a; b0.dat_i = d; b0.sel_i = 4'b0011; b0.we_i = 1'b1; b0.cyc_i = 1'b1; b0.stb_i = 1'b1;
        tick();
        chk({tag, "_ack"}, 16'(b0.ack_o), 16'h1);
        b0.cyc_i = 1'b0; b0.stb_i = 1'b0; b0.we_i = 1'b0;
        tick();
        chk({tag, "_ack_end"}, 16'(b0.ack_o), 16'h0);
    endtask

    initial begin
        b1.adr_i = '0; b1.dat_i = '0; b1.we_i = 1'b0; b1.sel_i = '0; b1.cyc_i = 1'b0; b1.stb_i = 1'b0;
        b0.adr_i = '0; b0.dat_i = '0; b0.we_i = 1'b0; b0.sel_i = '0; b0.cyc_i = 1'b0; b0.stb_i = 1'b0;
        tick();
        tick();
        chk("rst_ack1", 16'(b1.ack_o), 16'h0);
        chk("rst_dat1", b1.dat_o, 16'h0000);
        chk("rst_ack0", 16'(b0.ack_o), 16'h0);
        chk("rst_dat0", b0.dat_o, 16'h0000);
        reset = 1'b0;
        tick();

        wr1(16'h0004, 16'hBEEF, 4'b0011, "w4");
        rd1(16'h0004, 16'hBEEF, "r4");

        wr1(16'h0010, 16'h1234, 4'b0011, "w10a");
        wr1(16'h0010, 16'hAB00, 4'b0010, "w10b");
        rd1(16'h0010, 16'hAB34, "r10a");
        wr1(16'h0010, 16'hFFFF, 4'b0000, "w10none");
        wr1(16'h0010, 16'h5555, 4'b1100, "w10hi");
        rd1(16'h0010, 16'hAB34, "r10b");
        wr1(16'h0010, 16'h00CD, 4'b0001, "w10lo");
        rd1(16'h0010, 16'hABCD, "r10c");

        wr1(16'h0020, 16'h1111, 4'b0011, "w20");
        b1.adr_i = 16'h0020; b1.dat_i = 16'h2222; b1.sel_i = 4'b0011; b1.we_i = 1'b1; b1.cyc_i = 1'b1; b1.stb_i = 1'b1;
        tick();
        chk("abort_wait", 16'(b1.ack_o), 16'h0);
        b1.stb_i = 1'b0;
        tick();
        chk("abort_noack1", 16'(b1.ack_o), 16'h0);
        tick();
        chk("abort_noack2", 16'(b1.ack_o), 16'h0);
        b1.cyc_i = 1'b0; b1.we_i = 1'b0;
        rd1(16'h0020, 16'h1111, "r20");

        wr1(16'h0030, 16'h3333, 4'b0011, "w30");
        rd1(16'h0030, 16'h3333, "r30a");
        b1.adr_i = 16'h0030; b1.dat_i = 16'h4444; b1.sel_i = 4'b0011; b1.we_i = 1'b1; b1.cyc_i = 1'b1; b1.stb_i = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        chk("rstw_ack", 16'(b1.ack_o), 16'h0);
        chk("rstw_dat", b1.dat_o, 16'h0000);
        tick();
        chk("rstw_ack_edge", 16'(b1.ack_o), 16'h0);
        b1.cyc_i = 1'b0; b1.stb_i = 1'b0; b1.we_i = 1'b0;
        reset = 1'b0;
        tick();
        rd1(16'h0030, 16'h3333, "r30b");

        b1.adr_i = 16'h0004; b1.we_i = 1'b0; b1.cyc_i = 1'b1; b1.stb_i = 1'b1;
        tick();
        tick();
        chk("rsta_ack_pre", 16'(b1.ack_o), 16'h1);
        reset = 1'b1;
        #1;
        chk("rsta_ack", 16'(b1.ack_o), 16'h0);
        chk("rsta_dat", b1.dat_o, 16'h0000);
        b1.cyc_i = 1'b0; b1.stb_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        wr1(16'h0405, 16'h5A5A, 4'b0011, "w405");
        rd1(16'h0005, 16'h5A5A, "r005");

        wr0(16'h0001, 16'h0101, "w0_1");
        wr0(16'h0002, 16'h0202, "w0_2");
        wr0(16'h0003, 16'h0303, "w0_3");
        b0.adr_i = 16'h0001; b0.we_i = 1'b0; b0.cyc_i = 1'b1; b0.stb_i = 1'b1;
        tick();
        chk("b2b_ack1", 16'(b0.ack_o), 16'h1);
        chk("b2b_dat1", b0.dat_o, 16'h0101);
        b0.adr_i = 16'h0002;
        tick();
        chk("b2b_gap1", 16'(b0.ack_o), 16'h0);
        chk("b2b_hold1", b0.dat_o, 16'h0101);
        tick();
        chk("b2b_ack2", 16'(b0.ack_o), 16'h1);
        chk("b2b_dat2", b0.dat_o, 16'h0202);
        b0.adr_i = 16'h0003;
        tick();
        chk("b2b_gap2", 16'(b0.ack_o), 16'h0);
        tick();
        chk("b2b_ack3", 16'(b0.ack_o), 16'h1);
        chk("b2b_dat3", b0.dat_o, 16'h0303);
        b0.cyc_i = 1'b0; b0.stb_i = 1'b0;
        tick();
        chk("b2b_end", 16'(b0.ack_o), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
